// File: rtl/sdram_aref.sv
// sdram_aref: SDRAM auto-refresh generator (W9825G6KH, 100 MHz).
// Times the refresh interval, requests the arbiter, and on grant issues
// PRECHARGE-ALL followed by AREF_NUM AUTO-REFRESH commands, then pulses aref_end.
// Optional macro SDRAM_AREF_OVERRUN_EN adds the sticky aref_overrun output.
module sdram_aref #(
   parameter int AREF_PERIOD = 750,
   parameter int TRP_CLK     = 2,
   parameter int TRFC_CLK    = 7,
   parameter int AREF_NUM    = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        init_end,
   input  logic        aref_en,
   output logic        aref_req,
   output logic [3:0]  aref_cmd,
   output logic [1:0]  aref_bank,
   output logic [12:0] aref_addr,
   output logic        aref_end
`ifdef SDRAM_AREF_OVERRUN_EN
   ,
   output logic        aref_overrun
`endif
);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PCH  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   localparam int IW = $clog2(AREF_PERIOD);
   localparam logic [IW-1:0] IV_LAST = IW'(AREF_PERIOD - 1);

   // Wait counters count the NOP cycles between commands; the *_LAST
   // values are only reached when the corresponding wait is non-empty.
   localparam int CW = $clog2(TRP_CLK + TRFC_CLK + 1) + 1;
   localparam logic [CW-1:0] TRP_LAST = CW'(TRP_CLK - 2);
   localparam logic [CW-1:0] TRF_LAST = CW'(TRFC_CLK - 2);
   localparam logic [2:0]    AR_NUM   = 3'(AREF_NUM);

   typedef enum logic [2:0] {S_IDLE, S_PCH, S_TRP, S_AR, S_TRF, S_END} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] iv_q, iv_d;
   logic [CW-1:0] cnt_clk_q, cnt_clk_d;
   logic [2:0]    cnt_ar_q, cnt_ar_d;
   logic          req_q, req_d;
   logic          end_q, end_d;
   logic [3:0]    cmd_q, cmd_d;
   logic [1:0]    bank_q, bank_d;
   logic [12:0]   addr_q, addr_d;
   logic          wrap;

   // Interval counter and request flag; the counter free-runs so intervals are start-to-start
   always_comb begin
      wrap  = init_end && (iv_q == IV_LAST);
      iv_d  = '0;
      req_d = 1'b0;
      if (init_end) begin
         iv_d = wrap ? '0 : iv_q + 1'b1;
         if (wrap)         req_d = 1'b1;
         else if (aref_en) req_d = 1'b0;
         else              req_d = req_q;
      end
   end

   // Sequence FSM next-state: PRECHARGE, tRP wait, then AREF_NUM x (AUTO-REFRESH, tRFC wait)
   always_comb begin
      state_d   = state_q;
      cnt_clk_d = cnt_clk_q;
      cnt_ar_d  = cnt_ar_q;
      case (state_q)
         S_IDLE: begin
            if (aref_en) begin
               state_d  = S_PCH;
               cnt_ar_d = '0;
            end
         end
         S_PCH: begin
            cnt_clk_d = '0;
            state_d   = (TRP_CLK > 1) ? S_TRP : S_AR;
         end
         S_TRP: begin
            if (cnt_clk_q == TRP_LAST) state_d = S_AR;
            else                       cnt_clk_d = cnt_clk_q + 1'b1;
         end
         S_AR: begin
            cnt_ar_d  = cnt_ar_q + 3'd1;
            cnt_clk_d = '0;
            if (TRFC_CLK > 1)                    state_d = S_TRF;
            else if (cnt_ar_q + 3'd1 < AR_NUM)   state_d = S_AR;
            else                                 state_d = S_END;
         end
         S_TRF: begin
            if (cnt_clk_q == TRF_LAST) state_d = (cnt_ar_q < AR_NUM) ? S_AR : S_END;
            else                       cnt_clk_d = cnt_clk_q + 1'b1;
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered command outputs decoded from the next state so they line up with it
   always_comb begin
      cmd_d  = CMD_NOP;
      bank_d = 2'b11;
      addr_d = 13'h1fff;
      end_d  = (state_d == S_END);
      case (state_d)
         S_PCH:   cmd_d = CMD_PCH;
         S_AR:    cmd_d = CMD_AREF;
         default: cmd_d = CMD_NOP;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         iv_q      <= '0;
         cnt_clk_q <= '0;
         cnt_ar_q  <= '0;
         req_q     <= 1'b0;
         end_q     <= 1'b0;
         cmd_q     <= CMD_NOP;
         bank_q    <= 2'b11;
         addr_q    <= 13'h1fff;
      end else begin
         state_q   <= state_d;
         iv_q      <= iv_d;
         cnt_clk_q <= cnt_clk_d;
         cnt_ar_q  <= cnt_ar_d;
         req_q     <= req_d;
         end_q     <= end_d;
         cmd_q     <= cmd_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
      end
   end

   assign aref_req  = req_q;
   assign aref_end  = end_q;
   assign aref_cmd  = cmd_q;
   assign aref_bank = bank_q;
   assign aref_addr = addr_q;

`ifdef SDRAM_AREF_OVERRUN_EN
   logic ovr_q, ovr_d;

   // Sticky flag: an interval elapsed while the previous request was still pending
   always_comb begin
      ovr_d = ovr_q | (wrap & req_q);
   end

   // Overrun register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovr_q <= 1'b0;
      else       ovr_q <= ovr_d;
   end

   assign aref_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_sdram_aref.sv
// tb_sdram_aref: directed + randomized-grant bench with a latency-based reference model.
module tb_sdram_aref;
   localparam int P       = 750;
   localparam int TRP     = 2;
   localparam int TRFC    = 7;
   localparam int NUM     = 2;
   localparam int END_OFF = TRP + NUM * TRFC;   // aref_end offset from grant edge

   logic clk = 1'b0, rstn = 1'b0, init_end = 1'b0, aref_en = 1'b0;
   logic aref_req, aref_end;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_bank;
   logic [12:0] aref_addr;
`ifdef SDRAM_AREF_OVERRUN_EN
   logic aref_overrun;
`endif

   sdram_aref #(.AREF_PERIOD(P), .TRP_CLK(TRP), .TRFC_CLK(TRFC), .AREF_NUM(NUM)) dut (
      .clk(clk), .rstn(rstn), .init_end(init_end), .aref_en(aref_en),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_bank(aref_bank),
      .aref_addr(aref_addr), .aref_end(aref_end)
`ifdef SDRAM_AREF_OVERRUN_EN
      , .aref_overrun(aref_overrun)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: edges since init_end rose, and offset of the current sequence
   int   m_n   = 0;
   int   m_off = -1;
   logic m_req = 1'b0;
   logic m_ovr = 1'b0;

   function automatic bit wrap_now(int n);
      return (n % P) == P - 1;
   endfunction

   function automatic logic [3:0] exp_cmd(int off);
      if (off == 0) return 4'b0010;
      for (int k = 0; k < NUM; k++)
         if (off == TRP + k * TRFC) return 4'b0001;
      return 4'b0111;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_n <= 0; m_off <= -1; m_req <= 1'b0; m_ovr <= 1'b0;
      end else begin
         m_n <= init_end ? m_n + 1 : 0;
         if (!init_end)                 m_req <= 1'b0;
         else if (wrap_now(m_n))        m_req <= 1'b1;
         else if (aref_en)              m_req <= 1'b0;
         if (init_end && wrap_now(m_n) && m_req) m_ovr <= 1'b1;
         if (m_off < 0) m_off <= aref_en ? 0 : -1;
         else           m_off <= (m_off == END_OFF) ? -1 : m_off + 1;
      end
   end

   int npass = 0, nchk = 0, cyc = 0;
   int rise_cyc = 0, prev_rise = 0, rise_cnt = 0;
   int ar_cnt = 0, end_cnt = 0, pre_cyc = 0, first_ar_cyc = 0, end_cyc = 0;
   logic prev_req = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: compare every output with the model at the falling edge
   task automatic step();
      @(negedge clk);
      cyc++;
      chk("cmd",  {28'd0, aref_cmd}, {28'd0, exp_cmd(m_off)});
      chk("end",  {31'd0, aref_end}, {31'd0, (m_off == END_OFF)});
      chk("req",  {31'd0, aref_req}, {31'd0, m_req});
      chk("bank", {30'd0, aref_bank}, 32'h3);
      chk("addr", {19'd0, aref_addr}, 32'h1fff);
`ifdef SDRAM_AREF_OVERRUN_EN
      chk("ovr",  {31'd0, aref_overrun}, {31'd0, m_ovr});
`endif
      if (aref_req && !prev_req) begin
         prev_rise = rise_cyc; rise_cyc = cyc; rise_cnt++;
      end
      if (aref_cmd == 4'b0010) pre_cyc = cyc;
      if (aref_cmd == 4'b0001) begin
         if (ar_cnt == 0) first_ar_cyc = cyc;
         ar_cnt++;
      end
      if (aref_end) begin end_cyc = cyc; end_cnt++; end
      prev_req = aref_req;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!aref_req && n < P + 50) begin step(); n++; end
      chk("req_timeout", {31'd0, aref_req}, 32'd1);
   endtask

   // Arbiter: grant after lat clocks, hold aref_en until the cycle after aref_end
   task automatic grant(input int lat);
      int g0, n;
      repeat (lat) step();
      aref_en = 1'b1;
      g0 = cyc; ar_cnt = 0; end_cnt = 0; end_cyc = 0; n = 0;
      step();
      chk("req_clr", {31'd0, aref_req}, 32'd0);
      while (end_cnt == 0 && n < 40) begin step(); n++; end
      chk("end_seen", end_cnt, 1);
      step();
      aref_en = 1'b0;
      repeat (3) step();
      chk("pch_lat",  pre_cyc - g0, 1);
      chk("ar1_lat",  first_ar_cyc - g0, 1 + TRP);
      chk("end_lat",  end_cyc - g0, 1 + END_OFF);
      chk("ar_count", ar_cnt, NUM);
      chk("end_once", end_cnt, 1);
   endtask

   initial begin
      int c0, r0;
      // Reset state
      repeat (2) step();
      chk("rst_cmd", {28'd0, aref_cmd}, 32'h7);
      rstn = 1'b1;
      while (cyc < 5) step();
      init_end = 1'b1; c0 = cyc;
      wait_req();
      chk("first_req_lat", rise_cyc - c0, P);
      repeat (20) step();
      chk("req_hold", {31'd0, aref_req}, 32'd1);

      // First grant with unit latency
      grant(1);

      // Back-to-back intervals with random grant latency
      for (int i = 0; i < 3; i++) begin
         wait_req();
         chk("interval", rise_cyc - prev_rise, P);
         grant($urandom_range(1, 30));
      end

      // Reset in the middle of a sequence
      wait_req();
      aref_en = 1'b1;
      repeat (5) step();
      rstn = 1'b0; aref_en = 1'b0;
      #1;
      chk("rst_mid_cmd", {28'd0, aref_cmd}, 32'h7);
      chk("rst_mid_req", {31'd0, aref_req}, 32'd0);
      chk("rst_mid_end", {31'd0, aref_end}, 32'd0);
      repeat (2) step();
      rstn = 1'b1; c0 = cyc; ar_cnt = 0;
      wait_req();
      chk("ar_after_rst", ar_cnt, 0);
      chk("req_after_rst", rise_cyc - c0, P);
      grant(1);

      // init_end dropped mid-interval restarts the interval
      repeat ($urandom_range(100, 400)) step();
      init_end = 1'b0;
      repeat (3) step();
      chk("init_drop_req", {31'd0, aref_req}, 32'd0);
      init_end = 1'b1; c0 = cyc;
      wait_req();
      chk("req_after_init", rise_cyc - c0, P);
      grant(1);

      // Starved refresh: request stays up and is not duplicated
      wait_req();
      r0 = rise_cnt;
      repeat (1600) step();
      chk("no_dup_req", rise_cnt, r0);
      chk("starve_req", {31'd0, aref_req}, 32'd1);
`ifdef SDRAM_AREF_OVERRUN_EN
      chk("overrun", {31'd0, aref_overrun}, 32'd1);
`endif
      grant(1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
